// File: rtl/alu_pkg.sv
// Shared ALU result types and flag layout used by the ALU core, capture FIFO and display path.
// Constants only: no logic, no latency, no flow control.
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int FLAG_W = 4;

   localparam int ZF_BIT = 3;
   localparam int CF_BIT = 2;
   localparam int OF_BIT = 1;
   localparam int SF_BIT = 0;

   typedef struct packed {
      logic [FLAG_W-1:0] flags;
      logic [DATA_W-1:0] data;
   } alu_res_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
// Value visible one cycle after inc; no backpressure.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_F,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] value
);
   logic [W-1:0] r_value;

   always_ff @(posedge clk_F or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (inc && (r_value != {W{1'b1}})) begin
         r_value <= r_value + 1'b1;
      end
   end

   assign value = r_value;
endmodule

// File: rtl/alu_result_fifo.sv
// ALU result capture FIFO; head (or last popped) visible the cycle after push/pop; cap_ready=!full, full pushes dropped and counted.
// Optional sticky flag accumulation under ALU_FIFO_STICKY_FLAGS_EN.
module alu_result_fifo #(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int FLAG_W = alu_pkg::FLAG_W,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                       clk_F,
   input  logic                       rst_n,
   input  logic                       cap_valid,
   output logic                       cap_ready,
   input  logic [DATA_W-1:0]          cap_data,
   input  logic [FLAG_W-1:0]          cap_flags,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          dout,
   output logic [FLAG_W-1:0]          dout_flags,
   output logic                       dout_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic [FLAG_W-1:0]          sticky_flags,
   input  logic                       clr_sticky
);
   import alu_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int RES_W = FLAG_W + DATA_W;

   // Entries are stored {flags, data}, matching alu_res_t.
   logic [RES_W-1:0] r_mem [DEPTH];
   logic [RES_W-1:0] r_hold;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [RES_W-1:0] w_head;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = cap_valid && !w_full;
   assign w_pop   = rd_en && !w_empty;
   assign w_head  = w_empty ? r_hold : r_mem[r_rd_ptr];

   always_ff @(posedge clk_F) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cap_flags, cap_data};
      end
   end

   always_ff @(posedge clk_F or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_hold   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_hold   <= r_mem[r_rd_ptr];
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   sat_counter #(.W(DROP_W)) u_drop_cnt (
      .clk_F (clk_F),
      .rst_n (rst_n),
      .inc   (cap_valid && w_full),
      .value (drop_cnt)
   );

`ifdef ALU_FIFO_STICKY_FLAGS_EN
   logic [FLAG_W-1:0] r_sticky;

   // A clear coinciding with a push restarts accumulation from that push.
   always_ff @(posedge clk_F or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= '0;
      end else if (clr_sticky) begin
         r_sticky <= w_push ? cap_flags : '0;
      end else if (w_push) begin
         r_sticky <= r_sticky | cap_flags;
      end
   end

   assign sticky_flags = r_sticky;
`else
   logic w_unused_clr_sticky;
   assign w_unused_clr_sticky = clr_sticky;
   assign sticky_flags        = '0;
`endif

   assign dout       = w_head[DATA_W-1:0];
   assign dout_flags = w_head[RES_W-1:DATA_W];
   assign dout_valid = !w_empty;
   assign count      = r_count;
   assign full       = w_full;
   assign empty      = w_empty;
   assign cap_ready  = !w_full;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
   localparam int DATA_W = 32;
   localparam int FLAG_W = 4;
   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic              clk_F = 1'b0;
   logic              rst_n;
   logic              cap_valid;
   logic              cap_ready;
   logic [DATA_W-1:0] cap_data;
   logic [FLAG_W-1:0] cap_flags;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic [FLAG_W-1:0] dout_flags;
   logic              dout_valid;
   logic [$clog2(DEPTH):0] count;
   logic              full;
   logic              empty;
   logic [DROP_W-1:0] drop_cnt;
   logic [FLAG_W-1:0] sticky_flags;
   logic              clr_sticky;

   alu_result_fifo #(
      .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
   ) dut (
      .clk_F(clk_F), .rst_n(rst_n),
      .cap_valid(cap_valid), .cap_ready(cap_ready),
      .cap_data(cap_data), .cap_flags(cap_flags),
      .rd_en(rd_en),
      .dout(dout), .dout_flags(dout_flags), .dout_valid(dout_valid),
      .count(count), .full(full), .empty(empty),
      .drop_cnt(drop_cnt), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky)
   );

   always #5 clk_F = ~clk_F;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a queue of {flags,data} entries plus held value, drop count and sticky flags.
   logic [FLAG_W+DATA_W-1:0] m_q [$];
   logic [FLAG_W+DATA_W-1:0] m_hold;
   int                       m_drop;
   logic [FLAG_W-1:0]        m_sticky;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold   = '0;
      m_drop   = 0;
      m_sticky = '0;
   endtask

   task automatic check_all();
      logic [FLAG_W+DATA_W-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : m_hold;
      chk("dout",       64'(dout),       64'(head[DATA_W-1:0]));
      chk("dout_flags", 64'(dout_flags), 64'(head[FLAG_W+DATA_W-1:DATA_W]));
      chk("dout_valid", 64'(dout_valid), 64'(m_q.size() != 0));
      chk("count",      64'(count),      64'(m_q.size()));
      chk("full",       64'(full),       64'(m_q.size() == DEPTH));
      chk("empty",      64'(empty),      64'(m_q.size() == 0));
      chk("cap_ready",  64'(cap_ready),  64'(m_q.size() != DEPTH));
      chk("drop_cnt",   64'(drop_cnt),   64'(m_drop));
      chk("sticky",     64'(sticky_flags), 64'(m_sticky));
   endtask

   // One clock: drive inputs, advance the model at the edge, check #1 later.
   task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [FLAG_W-1:0] f,
                        input logic rd, input logic clr);
      bit is_full, is_empty, push, pop;
      cap_valid = v; cap_data = d; cap_flags = f; rd_en = rd; clr_sticky = clr;
      @(posedge clk_F);
      is_full  = (m_q.size() == DEPTH);
      is_empty = (m_q.size() == 0);
      push = v && !is_full;
      pop  = rd && !is_empty;
      if (v && is_full && m_drop < DROP_MAX) m_drop++;
`ifdef ALU_FIFO_STICKY_FLAGS_EN
      if (clr) m_sticky = push ? f : '0;
      else if (push) m_sticky = m_sticky | f;
`endif
      if (pop) m_hold = m_q.pop_front();
      if (push) m_q.push_back({f, d});
      #1;
      check_all();
   endtask

   initial begin
      int drop_before;
      rst_n = 1'b0; cap_valid = 0; cap_data = '0; cap_flags = '0; rd_en = 0; clr_sticky = 0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk_F);
      #1 rst_n = 1'b1;

      // First push becomes visible the next cycle
      cycle(1, 32'h5, 4'b0000, 0, 0);
      chk("first_dout", 64'(dout), 64'h5);
      cycle(0, 0, 0, 1, 0);

      // Fill, overflow, drain in order, held value
      for (int i = 1; i <= 4; i++) cycle(1, 32'(i * 'h11), 4'(i), 0, 0);
      chk("fill_full", 64'(full), 64'd1);
      cycle(1, 32'h55, 4'hF, 0, 0);
      chk("overflow_drop", 64'(drop_cnt), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", 64'(dout), 64'(i * 'h11));
         cycle(0, 0, 0, 1, 0);
      end
      chk("held_dout", 64'(dout), 64'h44);
      chk("held_valid", 64'(dout_valid), 64'd0);

      // Pointer wrap with paired push/pop
      cycle(1, 32'hA0, 4'h1, 0, 0);
      for (int i = 1; i <= 6; i++) cycle(1, 32'hA0 + 32'(i), 4'(i), 1, 0);
      chk("wrap_count", 64'(count), 64'd1);
      chk("wrap_head", 64'(dout), 64'hA6);
      cycle(0, 0, 0, 1, 0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) cycle(1, 32'hB0 + 32'(i), 4'(i), 0, 0);
      drop_before = int'(drop_cnt);
      cycle(1, 32'hBF, 4'hF, 1, 0);
      chk("full_rw_count", 64'(count), 64'd3);
      chk("full_rw_drop", 64'(drop_cnt), 64'(drop_before + 1));

      // Saturation of drop counter
      cycle(1, 32'hC0, 4'h0, 0, 0);
      for (int i = 0; i < 300; i++) cycle(1, 32'(i), 4'h0, 0, 0);
      chk("drop_sat", 64'(drop_cnt), 64'd255);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

`ifdef ALU_FIFO_STICKY_FLAGS_EN
      cycle(0, 0, 0, 0, 1);
      cycle(1, 32'hD1, 4'b1000, 0, 0);
      cycle(1, 32'hD2, 4'b0010, 0, 0);
      chk("sticky_or", 64'(sticky_flags), 64'b1010);
      cycle(1, 32'hD3, 4'b0001, 1, 1);
      chk("sticky_clr_push", 64'(sticky_flags), 64'b0001);
`endif

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
      end

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) cycle(1, 32'hE0 + 32'(i), 4'hA, 0, 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_dout", 64'(dout), 64'd0);
      @(posedge clk_F);
      #1 rst_n = 1'b1;
      cycle(1, 32'hF00D, 4'h3, 0, 0);
      for (int i = 0; i < 50; i++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 10));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
